// File: rtl/exc_ctrl.sv
// exc_ctrl: exception entry/return sequencer driving PC redirect, pipeline flushes and EPC/cause state
module exc_ctrl #(
  parameter logic [15:0] HANDLER_ADDR = 16'h00F0,
  parameter logic [15:0] PC_INC = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic        exc_cause,
  input  logic [15:0] exc_pc,
  input  logic        eret,
  output logic [1:0]  pc_sel,
  output logic [15:0] pc_target,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic [15:0] epc,
  output logic [1:0]  cause_reg,
  output logic        in_handler,
  output logic        exc_lost,
  output logic [7:0]  exc_count
);
  typedef enum logic [1:0] {IDLE, FLUSH, HANDLER, RETURN} state_t;
  state_t state_q, state_d;
  logic [15:0] epc_q;
  logic [1:0] cause_q;
  logic lost_q;
  logic [7:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (exc_valid ? FLUSH : IDLE) :
              state_q == FLUSH ? HANDLER :
              state_q == HANDLER ? (eret ? RETURN : HANDLER) : IDLE;
  end
  always_comb begin
    pc_sel = state_q == FLUSH ? 2'b01 : state_q == RETURN ? 2'b10 : 2'b00;
    pc_target = state_q == FLUSH ? HANDLER_ADDR : state_q == RETURN ? epc_q + PC_INC : 16'h0000;
    flush_if_id = state_q == FLUSH || state_q == RETURN;
    flush_id_ex = state_q == FLUSH;
    flush_ex_mem = state_q == FLUSH && cause_q[0];
    in_handler = state_q == HANDLER;
  end
  // Only IDLE accepts an exception; anything arriving elsewhere is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= '0;
      cause_q <= '0;
      lost_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (state_q == IDLE && exc_valid) begin
        epc_q <= exc_pc;
        cause_q <= {1'b1, exc_cause};
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end
      if (state_q != IDLE && exc_valid) lost_q <= 1'b1;
      if (state_q == RETURN) cause_q[1] <= 1'b0;
    end
  end
  assign epc = epc_q;
  assign cause_reg = cause_q;
  assign exc_lost = lost_q;
  assign exc_count = count_q;
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception controller that consumes the hazard unit's exception report (cause bit plus valid) and performs the pipeline's response. It latches EPC and cause, flushes the pipeline stages that hold bad instructions, and redirects the PC to the handler. On a return-from-exception it restores the PC to the instruction after the faulting one. It sits between the hazard unit and the PC-select mux and pipeline-register flush inputs.

## Interface
- HANDLER_ADDR, 16'h00F0, PC loaded on exception entry
- PC_INC, 16'd2, offset added to EPC on return (skips faulting instruction)
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- exc_valid  in  1  exception reported this cycle
- exc_cause  in  1  0 = invalid opcode (detected in ID), 1 = arithmetic overflow (detected in EX)
- exc_pc  in  16  PC of faulting instruction, valid with exc_valid
- eret  in  1  return-from-exception decoded in ID
- pc_sel  out  2  00 normal, 01 handler, 10 return; 11 never driven
- pc_target  out  16  redirect address, valid when pc_sel != 00, else 0
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  pipeline-register flushes
- epc  out  16  saved exception PC
- cause_reg  out  2  {valid, cause}
- in_handler  out  1  high in HANDLER state
- exc_lost  out  1  sticky: an exception arrived while not in IDLE
- exc_count  out  8  accepted exceptions, saturating at 255

## Operation
- States: IDLE, FLUSH, HANDLER, RETURN. Moore outputs decoded from state; epc, cause_reg, exc_count, exc_lost are registers.
- IDLE: pc_sel=00, no flushes. exc_valid=1 → FLUSH. At that edge: epc←exc_pc, cause_reg←{1,exc_cause}, exc_count←min(count+1,255).
- FLUSH (exactly 1 cycle): pc_sel=01, pc_target=HANDLER_ADDR.
  - flush_if_id=1 and flush_id_ex=1 always.
  - flush_ex_mem=cause_reg[0] (overflow also kills EX/MEM).
  - Unconditional → HANDLER.
- HANDLER: in_handler=1, pc_sel=00. eret=1 → RETURN; otherwise stay.
- RETURN (exactly 1 cycle): pc_sel=10, pc_target=(epc+PC_INC) mod 2^16, flush_if_id=1. → IDLE.
  - At that edge cause_reg[1]←0; epc is held.
- eret in IDLE, FLUSH, or RETURN: ignored.
- Any exc_valid in FLUSH, HANDLER, or RETURN:
  - not accepted (no nesting); epc, cause_reg, and exc_count are unchanged.
  - exc_lost←1.
- exc_valid and eret together in HANDLER: eret taken, exception lost (exc_lost←1).
- Reset values: state IDLE, pc_sel=00, pc_target=0, all flushes 0, epc=0, cause_reg=00, in_handler=0, exc_lost=0, exc_count=0.
- rst in any state: all of the above apply at the next edge. An in-progress FLUSH/RETURN is abandoned.

## Timing
- exc_valid sampled in cycle N (IDLE). FLUSH outputs and updated epc/cause_reg are visible in cycle N+1. in_handler=1 from N+2.
- eret sampled in cycle M (HANDLER). RETURN outputs are visible in M+1, and IDLE holds from M+2.
  - cause_reg[1]=0 from M+2.
  - A new exception can be accepted in M+2.
- Minimum exception-to-exception spacing: 4 cycles (exc, FLUSH, eret cycle in HANDLER, RETURN).
- Flushes and pc_sel are asserted for exactly one cycle per event, never in the same cycle as each other's opposite redirect.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then 10 idle cycles → every output equals its reset value throughout.
- Invalid-opcode entry:
  - Stimulus: exc_valid=1, exc_cause=0, exc_pc=16'h0040 in cycle N.
  - N+1: pc_sel=01, pc_target=16'h00F0, flush_if_id=1, flush_id_ex=1, flush_ex_mem=0, epc=16'h0040, cause_reg=2'b10.
  - N+2: in_handler=1, exc_count=1.
- Overflow entry and return:
  - Stimulus: exc_cause=1, exc_pc=16'h1234; eret 3 cycles after entry.
  - FLUSH cycle: flush_ex_mem=1, cause_reg=2'b11.
  - RETURN cycle: pc_sel=10, pc_target=16'h1236, flush_if_id=1.
  - Next cycle: cause_reg=2'b01, state IDLE.
- Wrap and saturation:
  - exc_pc=16'hFFFF then eret → return pc_target=16'h0001.
  - 256 full exception/eret sequences → exc_count=255.
- Collision:
  - exc_valid during FLUSH, and exc_valid+eret together in HANDLER → epc/cause unchanged, exc_lost=1, eret honoured (RETURN next cycle).
- Reset mid-operation:
  - rst asserted in the FLUSH cycle → next cycle all flushes 0, pc_sel=00, epc=0, exc_count=0.
  - A later exc_valid is accepted normally.
